// File: rtl/pipe_collision_scorer.sv
// Collision/floor detection and pipe-clear scoring for the flappy game.
// One evaluation per clk_2ms tick; all outputs registered.
module pipe_collision_scorer #(
  parameter int pip_width  = 100,
  parameter int pip_height = 100,
  parameter int bird_X     = 200,
  parameter int bird_size  = 20,
  parameter int floor_Y    = 480,
  parameter int score_max  = 999
) (
  input  logic       clk_2ms,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [9:0] pip_X,
  input  logic [8:0] pip_Y,
  input  logic [8:0] bird_Y,
  output logic       hit,
  output logic       pass_pulse,
  output logic       game_over,
  output logic [9:0] score
);

  typedef enum logic [1:0] {IDLE, ARMED, PASSED, OVER} fsm_t;

  localparam logic [10:0] BX      = 11'(bird_X);
  localparam logic [10:0] BS      = 11'(bird_size);
  localparam logic [10:0] PW      = 11'(pip_width);
  localparam logic [10:0] PH      = 11'(pip_height);
  localparam logic [10:0] FY      = 11'(floor_Y);
  localparam logic [10:0] X_FAR   = BX + BS + PW;
  localparam logic [9:0]  SCR_MAX = 10'(score_max);

  fsm_t        fsm, fsm_n;
  logic        hit_n, pass_n, go_n;
  logic [9:0]  score_n;
  logic [10:0] px, py, by;
  logic        colx, outgap, flr, collide, behind, respawn;

  assign px = {1'b0, pip_X};
  assign py = {2'b00, pip_Y};
  assign by = {2'b00, bird_Y};

  // Subtractions moved to the opposite side so no term can underflow.
  assign colx    = (px > BX) && (px < X_FAR);
  assign outgap  = (by + PH < py) || (by + BS > py);
  assign flr     = (by + BS > FY);
  assign collide = (colx && outgap) || flr;
  assign behind  = (px <= BX);
  assign respawn = (px >= X_FAR);

  always_comb begin
    fsm_n   = fsm;
    hit_n   = 1'b0;
    pass_n  = 1'b0;
    go_n    = game_over;
    score_n = score;
    if (state == 2'd0) begin
      fsm_n   = IDLE;
      go_n    = 1'b0;
      score_n = '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          go_n    = 1'b0;
          score_n = '0;
          if (state == 2'd1) fsm_n = behind ? PASSED : ARMED;
        end
        ARMED, PASSED: begin
          if (state == 2'd1) begin
            if (collide) begin
              hit_n = 1'b1;
              go_n  = 1'b1;
              fsm_n = OVER;
            end else if (fsm == ARMED && behind) begin
              pass_n  = 1'b1;
              score_n = (score >= SCR_MAX) ? score : score + 10'd1;
              fsm_n   = PASSED;
            end else if (fsm == PASSED && respawn) begin
              fsm_n = ARMED;
            end
          end
        end
        OVER: ;
        default: fsm_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2ms or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      hit        <= 1'b0;
      pass_pulse <= 1'b0;
      game_over  <= 1'b0;
      score      <= '0;
    end else begin
      fsm        <= fsm_n;
      hit        <= hit_n;
      pass_pulse <= pass_n;
      game_over  <= go_n;
      score      <= score_n;
    end
  end

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Scoreboard bench for pipe_collision_scorer: a behavioural game model pushes
// expected outputs per tick; they are popped and compared after the edge.
module tb_pipe_collision_scorer;

  logic       clk_2ms = 1'b0;
  logic       rst     = 1'b1;
  logic [1:0] state   = 2'd0;
  logic [9:0] pip_X   = '0;
  logic [8:0] pip_Y   = 9'd300;
  logic [8:0] bird_Y  = 9'd250;
  logic       hit, pass_pulse, game_over;
  logic [9:0] score;

  pipe_collision_scorer #(
    .pip_width(100), .pip_height(100), .bird_X(200),
    .bird_size(20), .floor_Y(480), .score_max(999)
  ) dut (
    .clk_2ms(clk_2ms), .rst(rst), .state(state), .pip_X(pip_X),
    .pip_Y(pip_Y), .bird_Y(bird_Y), .hit(hit), .pass_pulse(pass_pulse),
    .game_over(game_over), .score(score)
  );

  always #5 clk_2ms = ~clk_2ms;

  typedef struct {int h; int p; int g; int s;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // model: 0 idle, 1 armed, 2 passed, 3 over
  int m_fsm = 0, m_score = 0, m_go = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input int st, input int px, input int py, input int by);
    exp_t e, o;
    bit coll;
    state  = 2'(st);
    pip_X  = 10'(px);
    pip_Y  = 9'(py);
    bird_Y = 9'(by);
    coll = ((px > 200) && (px < 320) && ((by + 100 < py) || (by + 20 > py)))
           || (by + 20 > 480);
    e = '{0, 0, m_go, m_score};
    if (st == 0) begin
      m_fsm = 0; m_score = 0; m_go = 0;
    end else if (m_fsm == 0) begin
      m_score = 0; m_go = 0;
      if (st == 1) m_fsm = (px <= 200) ? 2 : 1;
    end else if ((m_fsm == 1 || m_fsm == 2) && st == 1) begin
      if (coll) begin
        e.h = 1; m_go = 1; m_fsm = 3;
      end else if (m_fsm == 1 && px <= 200) begin
        e.p = 1; m_fsm = 2;
        if (m_score < 999) m_score++;
      end else if (m_fsm == 2 && px >= 320) begin
        m_fsm = 1;
      end
    end
    e.g = m_go;
    e.s = m_score;
    sb.push_back(e);
    @(posedge clk_2ms);
    #1;
    o = sb.pop_front();
    check("hit", int'(hit), o.h);
    check("pass_pulse", int'(pass_pulse), o.p);
    check("game_over", int'(game_over), o.g);
    check("score", int'(score), o.s);
    if (hit && pass_pulse) check("hit_pass_exclusive", 1, 0);
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_hit", int'(hit), 0);
    check("rst_pass", int'(pass_pulse), 0);
    check("rst_go", int'(game_over), 0);
    check("rst_score", int'(score), 0);
    m_fsm = 0; m_score = 0; m_go = 0;
    #2 rst = 1'b0;
  endtask

  task automatic one_pass();
    step(1, 400, 300, 250);
    step(1, 200, 300, 250);
  endtask

  initial begin
    #1;
    check("por_score", int'(score), 0);
    check("por_go", int'(game_over), 0);
    @(posedge clk_2ms); #1 rst = 1'b0;

    // in-gap flight then climb into the top pipe
    step(0, 0, 300, 250);
    step(1, 320, 300, 250);
    for (int x = 319; x >= 251; x -= 4) step(1, x, 300, 250);
    step(1, 250, 300, 190);
    for (int i = 0; i < 3; i++) step(1, 150, 300, 250);
    check("over_score", int'(score), 0);

    // pass, hold behind, respawn, pass again
    step(0, 0, 300, 250);
    step(1, 320, 300, 250);
    step(1, 201, 300, 250);
    step(1, 200, 300, 250);
    for (int i = 0; i < 4; i++) step(1, 150, 300, 250);
    step(1, 740, 300, 250);
    for (int x = 739; x > 200; x -= 9) step(1, x, 300, 250);
    step(1, 200, 300, 250);
    check("score_two", int'(score), 2);

    // reach score 5, arm, then async reset mid-tick
    for (int i = 0; i < 3; i++) one_pass();
    step(1, 400, 300, 250);
    check("score_five", int'(score), 5);
    async_reset();

    // floor hit then restart clears
    step(1, 600, 300, 461);
    step(1, 600, 300, 461);
    step(1, 600, 300, 250);
    step(0, 600, 300, 250);

    // paused while crossing, resume behind bird
    step(1, 320, 300, 250);
    step(1, 201, 300, 250);
    step(2, 180, 300, 250);
    step(3, 150, 300, 250);
    step(1, 150, 300, 250);
    check("pause_resume_score", int'(score), 1);

    // saturation
    for (int i = 0; i < 1000; i++) one_pass();
    check("sat_score", int'(score), 999);
    one_pass();

    // collision and pass on the same tick: floor hit while crossing
    step(0, 0, 300, 250);
    step(1, 400, 300, 250);
    step(1, 200, 300, 461);

    // randomized play
    step(0, 0, 300, 250);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0) ? 0 : (($urandom_range(0, 9) == 0) ? 2 : 1),
           $urandom_range(0, 740), $urandom_range(100, 479), $urandom_range(0, 470));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    check("timeout", 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "FAIL timeout");
  end

endmodule
